// File: rtl/sysid_read_arbiter.sv
// Round-robin read arbiter sharing the sysid slave among NUM_MASTERS Avalon-MM read masters.
// Optional macro SYSID_ARB_CACHE_EN adds a two-word read cache that bypasses the slave on hits.
module sysid_read_arbiter #(
   parameter int NUM_MASTERS  = 2,
   parameter int READ_LATENCY = 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_MASTERS-1:0] m_read,
   input  logic [NUM_MASTERS-1:0] m_address,
   output logic [NUM_MASTERS-1:0] m_waitrequest,
   output logic [NUM_MASTERS-1:0] m_readdatavalid,
   output logic [31:0]            m_readdata,
   output logic                   s_address,
   input  logic [31:0]            s_readdata,
   output logic                   busy
);
   localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;

   state_t                 state_q, state_d;
   logic [1:0]             cnt_q, cnt_d;
   logic [GW-1:0]          grant_q, grant_d;
   logic [GW-1:0]          last_q, last_d;
   logic                   s_addr_q, s_addr_d;
   logic [31:0]            data_q, data_d;
   logic [NUM_MASTERS-1:0] gmask;
   logic [NUM_MASTERS-1:0] arb_req;
   logic [GW-1:0]          ptr;
   logic [GW-1:0]          pick;
   logic                   launch;
`ifdef SYSID_ARB_CACHE_EN
   logic [1:0][31:0]       cache_q, cache_d;
   logic [1:0]             cval_q, cval_d;
   logic                   hit;
`endif

   // First requester strictly after ptr_i, wrapping; ptr_i itself has lowest priority.
   function automatic logic [GW-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                             input logic [GW-1:0] ptr_i);
      logic [GW-1:0] sel;
      int idx;
      sel = ptr_i;
      for (int k = NUM_MASTERS; k >= 1; k--) begin
         idx = (int'(ptr_i) + k) % NUM_MASTERS;
         if (req[idx]) sel = GW'(idx);
      end
      return sel;
   endfunction

   assign gmask         = NUM_MASTERS'(1) << grant_q;
   assign m_waitrequest = m_read & ~({NUM_MASTERS{state_q == RESPOND}} & gmask);
   assign s_address     = s_addr_q;
   assign busy          = (state_q != IDLE);

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      grant_d         = grant_q;
      last_d          = last_q;
      s_addr_d        = s_addr_q;
      data_d          = data_q;
      m_readdatavalid = '0;
      m_readdata      = '0;
      launch          = 1'b0;
`ifdef SYSID_ARB_CACHE_EN
      cache_d         = cache_q;
      cval_d          = cval_q;
`endif
      // While responding, the current grant is excluded and becomes the rotation pointer.
      arb_req = m_read;
      ptr     = last_q;
      if (state_q == RESPOND) begin
         arb_req = m_read & ~gmask;
         ptr     = grant_q;
      end
      pick = rr_pick(arb_req, ptr);
`ifdef SYSID_ARB_CACHE_EN
      hit = cval_q[m_address[pick]];
`endif

      case (state_q)
         IDLE: begin
            launch = |arb_req;
         end
         ISSUE: begin
            if (cnt_q == 2'd0) begin
               data_d  = s_readdata;
               state_d = RESPOND;
`ifdef SYSID_ARB_CACHE_EN
               cache_d[s_addr_q] = s_readdata;
               cval_d[s_addr_q]  = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         RESPOND: begin
            m_readdatavalid = gmask;
            m_readdata      = data_q;
            last_d          = grant_q;
            state_d         = IDLE;
            launch          = |arb_req;
         end
         default: state_d = IDLE;
      endcase

      if (launch) begin
         grant_d = pick;
`ifdef SYSID_ARB_CACHE_EN
         if (hit) begin
            data_d  = cache_q[m_address[pick]];
            state_d = RESPOND;
         end else
`endif
         begin
            s_addr_d = m_address[pick];
            cnt_d    = CNT_INIT;
            state_d  = ISSUE;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= 2'd0;
         grant_q  <= '0;
         last_q   <= GW'(NUM_MASTERS - 1);
         s_addr_q <= 1'b0;
         data_q   <= '0;
`ifdef SYSID_ARB_CACHE_EN
         cache_q  <= '0;
         cval_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         grant_q  <= grant_d;
         last_q   <= last_d;
         s_addr_q <= s_addr_d;
         data_q   <= data_d;
`ifdef SYSID_ARB_CACHE_EN
         cache_q  <= cache_d;
         cval_q   <= cval_d;
`endif
      end
   end

endmodule

// File: tb/tb_sysid_read_arbiter.sv
// Bench for sysid_read_arbiter: directed protocol cases plus randomized two-master traffic
// checked against a transaction-level model (slave contents, round-robin order, fairness).
module tb_sysid_read_arbiter;
   localparam int N = 2;
   localparam logic [31:0] ID_WORD = 32'h00000007;
   localparam logic [31:0] TS_WORD = 32'h528D140E;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [N-1:0]  m_read = '0;
   logic [N-1:0]  m_address = '0;
   logic [N-1:0]  m_waitrequest;
   logic [N-1:0]  m_readdatavalid;
   logic [31:0]   m_readdata;
   logic          s_address;
   logic [31:0]   s_readdata;
   logic          busy;

   int tests = 0;
   int fails = 0;
   int order_q[$];
   int lat;
   logic [31:0] rd;
   int n0, n1, c0, c1;

   always #5 clock = ~clock;

   function automatic logic [31:0] slave_word(input logic a);
      return a ? TS_WORD : ID_WORD;
   endfunction

   assign s_readdata = slave_word(s_address);

   sysid_read_arbiter #(.NUM_MASTERS(N), .READ_LATENCY(1)) dut (
      .clock           (clock),
      .reset           (reset),
      .m_read          (m_read),
      .m_address       (m_address),
      .m_waitrequest   (m_waitrequest),
      .m_readdatavalid (m_readdatavalid),
      .m_readdata      (m_readdata),
      .s_address       (s_address),
      .s_readdata      (s_readdata),
      .busy            (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset;
      reset  = 1'b1;
      m_read = '0;
      step();
      step();
      reset  = 1'b0;
   endtask

   // Avalon masters: hold read until accepted, optionally pause, re-request with a fresh address.
   task automatic run_traffic(input int r0, input int r1, input bit gaps);
      int rem[N];
      int wt[N];
      int budget;
      logic [N-1:0] acc;
      rem[0] = r0;
      rem[1] = r1;
      order_q.delete();
      for (int i = 0; i < N; i++) begin
         wt[i] = 0;
         m_read[i] = (rem[i] > 0);
         m_address[i] = 1'($urandom_range(0, 1));
      end
      budget = 40 * (r0 + r1) + 20;
      while ((rem[0] > 0 || rem[1] > 0) && budget > 0) begin
         @(negedge clock);
         acc = m_read & ~m_waitrequest;
         chk("single accept", 32'($countones(acc)), (acc == '0) ? 32'd0 : 32'd1);
         for (int i = 0; i < N; i++) begin
            chk("rdv matches accept", 32'(m_readdatavalid[i]), 32'(acc[i]));
            if (acc[i]) begin
               chk("traffic data", m_readdata, slave_word(m_address[i]));
               chk("no starvation", 32'(wt[i] <= N - 1), 32'd1);
               wt[i] = 0;
               order_q.push_back(i);
               rem[i]--;
               for (int j = 0; j < N; j++)
                  if (j != i && m_read[j]) wt[j]++;
            end
         end
         step();
         for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
               if (rem[i] > 0 && !(gaps && $urandom_range(0, 1) == 0)) begin
                  m_read[i] = 1'b1;
                  m_address[i] = 1'($urandom_range(0, 1));
               end else begin
                  m_read[i] = 1'b0;
               end
            end else if (!m_read[i] && rem[i] > 0 && (!gaps || $urandom_range(0, 2) == 0)) begin
               m_read[i] = 1'b1;
               m_address[i] = 1'($urandom_range(0, 1));
            end
         end
         budget--;
      end
      chk("traffic within budget", 32'(budget > 0), 32'd1);
      m_read = '0;
   endtask

   task automatic single_read(input int i, input logic a, output int l, output logic [31:0] d);
      l = 0;
      d = 'x;
      m_read[i] = 1'b1;
      m_address[i] = a;
      while (l < 20) begin
         @(negedge clock);
         if (!m_waitrequest[i]) begin
            d = m_readdata;
            break;
         end
         step();
         l++;
      end
      step();
      m_read[i] = 1'b0;
   endtask

   initial begin
      // Reset state with no requests
      step();
      step();
      reset = 1'b0;
      @(negedge clock);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset waitrequest", 32'(m_waitrequest), 32'd0);
      chk("reset rdv", 32'(m_readdatavalid), 32'd0);
      chk("reset readdata", m_readdata, 32'd0);

      // Single master 0 read of timestamp; address wiggle after grant is ignored
      do_reset();
      m_read = 2'b01;
      m_address = 2'b01;
      @(negedge clock);
      chk("t2 c0 wait", 32'(m_waitrequest[0]), 32'd1);
      chk("t2 c0 rdv", 32'(m_readdatavalid), 32'd0);
      step();
      m_address = 2'b00;
      @(negedge clock);
      chk("t2 c1 wait", 32'(m_waitrequest[0]), 32'd1);
      chk("t2 c1 busy", 32'(busy), 32'd1);
      step();
      @(negedge clock);
      chk("t2 c2 wait", 32'(m_waitrequest[0]), 32'd0);
      chk("t2 c2 rdv", 32'(m_readdatavalid), 32'd1);
      chk("t2 c2 data", m_readdata, TS_WORD);
      step();
      m_read = '0;
      @(negedge clock);
      chk("t2 c3 busy", 32'(busy), 32'd0);

      // Simultaneous requests; master 1 drops read while granted and still gets its pulse
      do_reset();
      m_read = 2'b11;
      m_address = 2'b10;
      @(negedge clock);
      chk("t3 c0 wait", 32'(m_waitrequest), 32'd3);
      step();
      step();
      @(negedge clock);
      chk("t3 c2 rdv", 32'(m_readdatavalid), 32'd1);
      chk("t3 c2 data", m_readdata, ID_WORD);
      chk("t3 c2 wait", 32'(m_waitrequest), 32'd2);
      step();
      m_read = 2'b00;
      @(negedge clock);
      chk("t3 c3 busy", 32'(busy), 32'd1);
      chk("t3 c3 rdv", 32'(m_readdatavalid), 32'd0);
      step();
      @(negedge clock);
      chk("t3 c4 rdv", 32'(m_readdatavalid), 32'd2);
      chk("t3 c4 data", m_readdata, TS_WORD);

      // Continuous requests: last grant was 1, so order alternates starting with master 0
      run_traffic(3, 3, 1'b0);
      chk("t4 count", 32'(order_q.size()), 32'd6);
      c0 = 0;
      foreach (order_q[k]) begin
         chk("t4 order", 32'(order_q[k]), 32'(k % 2));
         if (order_q[k] == 0) c0++;
      end
      chk("t4 master0 share", 32'(c0), 32'd3);

      // Reset during master 1's ISSUE cycle
      do_reset();
      m_read = 2'b10;
      m_address = 2'b10;
      @(negedge clock);
      chk("t5 c0 wait", 32'(m_waitrequest[1]), 32'd1);
      step();
      chk("t5 issue busy", 32'(busy), 32'd1);
      reset = 1'b1;
      m_read = '0;
      #1;
      chk("t5 reset busy", 32'(busy), 32'd0);
      chk("t5 reset rdv", 32'(m_readdatavalid), 32'd0);
      step();
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         chk("t5 no rdv", 32'(m_readdatavalid), 32'd0);
         step();
      end
      run_traffic(1, 1, 1'b0);
      chk("t5 count", 32'(order_q.size()), 32'd2);
      if (order_q.size() > 0) chk("t5 first winner", 32'(order_q[0]), 32'd0);

      // Randomized traffic with gaps
      for (int r = 0; r < 4; r++) begin
         n0 = $urandom_range(4, 12);
         n1 = $urandom_range(4, 12);
         run_traffic(n0, n1, 1'b1);
         c0 = 0;
         c1 = 0;
         foreach (order_q[k]) if (order_q[k] == 0) c0++; else c1++;
         chk("rand master0 total", 32'(c0), 32'(n0));
         chk("rand master1 total", 32'(c1), 32'(n1));
         @(negedge clock);
         chk("rand idle after", 32'(busy), 32'd0);
         step();
      end

`ifdef SYSID_ARB_CACHE_EN
      do_reset();
      single_read(0, 1'b0, lat, rd);
      chk("cache miss0 latency", 32'(lat), 32'd2);
      chk("cache miss0 data", rd, ID_WORD);
      single_read(0, 1'b1, lat, rd);
      chk("cache miss1 latency", 32'(lat), 32'd2);
      chk("cache miss1 data", rd, TS_WORD);
      single_read(0, 1'b0, lat, rd);
      chk("cache hit latency", 32'(lat), 32'd1);
      chk("cache hit data", rd, ID_WORD);
      chk("cache hit s_address held", 32'(s_address), 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
